// File: rtl/speicher_pkg.sv
// Shared types for the unified-memory arbiter: controller states, requester
// identities and the width helper for the timeout counter.
package speicher_pkg;

    typedef enum logic [1:0] {
        FREI      = 2'd0,
        ZUGRIFF   = 2'd1,
        ABSCHLUSS = 2'd2
    } zustand_t;

    typedef enum logic [1:0] {
        EIGNER_INSTR = 2'd0,
        EIGNER_DATEN = 2'd1,
        EIGNER_LADER = 2'd2
    } eigner_t;

    localparam int TIMEOUT_STANDARD = 16;

    // Counter must hold 0 .. TIMEOUT-1.
    function automatic int zaehler_breite(input int timeout);
        if (timeout > 2) begin
            return $clog2(timeout);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/speicher_zeitgeber.sv
// Access timeout counter: cleared on Start, counts while Laeuft, flags the
// last permitted wait cycle through Abgelaufen.
module speicher_zeitgeber
    import speicher_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_STANDARD
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    input  logic Laeuft,
    output logic Abgelaufen
);

    localparam int BREITE = zaehler_breite(TIMEOUT);
    localparam logic [BREITE-1:0] GRENZE = BREITE'(TIMEOUT - 1);

    logic [BREITE-1:0] zaehler_q;
    logic [BREITE-1:0] zaehler_d;

    // Next count: restart wins over counting.
    always_comb begin
        zaehler_d = zaehler_q;
        if (Start) begin
            zaehler_d = '0;
        end else if (Laeuft) begin
            zaehler_d = zaehler_q + BREITE'(1);
        end else begin
            zaehler_d = zaehler_q;
        end
    end

    // Counter register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zaehler_q <= '0;
        end else begin
            zaehler_q <= zaehler_d;
        end
    end

    assign Abgelaufen = (zaehler_q == GRENZE);

endmodule

// File: rtl/speicher_arbiter.sv
// Single-port RAM arbiter for instruction fetch, data port and program loader.
// One atomic access at a time, loader first, round-robin between CPU ports.
module speicher_arbiter
    import speicher_pkg::*;
#(
    parameter int WORDSIZE     = 32,
    parameter int ADRESSBREITE = 32,
    parameter int TIMEOUT      = TIMEOUT_STANDARD
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    LadeAn,
    input  logic [ADRESSBREITE-1:0] LadeAdresse,
    input  logic [WORDSIZE-1:0]     LadeDaten,
    output logic                    LadeFertig,
    input  logic                    LeseInstruktion,
    input  logic [ADRESSBREITE-1:0] InstruktionAdresse,
    output logic [WORDSIZE-1:0]     Instruktion,
    output logic                    InstruktionGeladen,
    input  logic                    LeseDaten,
    input  logic                    SchreibeDaten,
    input  logic [ADRESSBREITE-1:0] DatenAdresse,
    input  logic [WORDSIZE-1:0]     DatenRaus,
    output logic [WORDSIZE-1:0]     DatenRein,
    output logic                    DatenGeladen,
    output logic                    DatenGespeichert,
    output logic                    RamLesenAn,
    output logic                    RamSchreibenAn,
    output logic [ADRESSBREITE-1:0] RamAdresse,
    output logic [WORDSIZE-1:0]     RamDatenRein,
    input  logic [WORDSIZE-1:0]     RamDatenRaus,
    input  logic                    RamDatenBereit,
    input  logic                    RamDatenGeschrieben,
    output logic                    Fehler
);

    zustand_t                zustand_q, zustand_d;
    eigner_t                 letzter_q, letzter_d;
    eigner_t                 eigner_q, eigner_d;
    logic                    schreiben_q, schreiben_d;
    logic                    ram_lesen_q, ram_lesen_d;
    logic                    ram_schreiben_q, ram_schreiben_d;
    logic [ADRESSBREITE-1:0] ram_adresse_q, ram_adresse_d;
    logic [WORDSIZE-1:0]     ram_daten_q, ram_daten_d;
    logic [WORDSIZE-1:0]     instruktion_q, instruktion_d;
    logic [WORDSIZE-1:0]     daten_rein_q, daten_rein_d;
    logic                    lade_fertig_q, lade_fertig_d;
    logic                    instr_geladen_q, instr_geladen_d;
    logic                    daten_geladen_q, daten_geladen_d;
    logic                    daten_gespeichert_q, daten_gespeichert_d;
    logic                    fehler_q, fehler_d;

    logic                    start_s;
    logic                    laeuft_s;
    logic                    abgelaufen_s;
    logic                    cpu_daten_s;
    logic                    fertig_s;
    logic [WORDSIZE-1:0]     wert_s;

    speicher_zeitgeber #(
        .TIMEOUT (TIMEOUT)
    ) u_zeitgeber (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (start_s),
        .Laeuft     (laeuft_s),
        .Abgelaufen (abgelaufen_s)
    );

    // Grant selection, transaction sequencing and result capture.
    always_comb begin
        zustand_d           = zustand_q;
        letzter_d           = letzter_q;
        eigner_d            = eigner_q;
        schreiben_d         = schreiben_q;
        ram_lesen_d         = ram_lesen_q;
        ram_schreiben_d     = ram_schreiben_q;
        ram_adresse_d       = ram_adresse_q;
        ram_daten_d         = ram_daten_q;
        instruktion_d       = instruktion_q;
        daten_rein_d        = daten_rein_q;
        lade_fertig_d       = 1'b0;
        instr_geladen_d     = 1'b0;
        daten_geladen_d     = 1'b0;
        daten_gespeichert_d = 1'b0;
        fehler_d            = 1'b0;
        start_s             = 1'b0;
        laeuft_s            = 1'b0;
        cpu_daten_s         = LeseDaten | SchreibeDaten;
        fertig_s            = schreiben_q ? RamDatenGeschrieben : RamDatenBereit;
        wert_s              = fertig_s ? RamDatenRaus : '0;

        case (zustand_q)
            FREI: begin
                if (LadeAn) begin
                    eigner_d        = EIGNER_LADER;
                    schreiben_d     = 1'b1;
                    ram_schreiben_d = 1'b1;
                    ram_adresse_d   = LadeAdresse;
                    ram_daten_d     = LadeDaten;
                    start_s         = 1'b1;
                    zustand_d       = ZUGRIFF;
                end else if (LeseInstruktion && (!cpu_daten_s || (letzter_q != EIGNER_INSTR))) begin
                    eigner_d      = EIGNER_INSTR;
                    letzter_d     = EIGNER_INSTR;
                    schreiben_d   = 1'b0;
                    ram_lesen_d   = 1'b1;
                    ram_adresse_d = InstruktionAdresse;
                    start_s       = 1'b1;
                    zustand_d     = ZUGRIFF;
                end else if (cpu_daten_s) begin
                    // A simultaneous read and write request is served as a write.
                    eigner_d        = EIGNER_DATEN;
                    letzter_d       = EIGNER_DATEN;
                    schreiben_d     = SchreibeDaten;
                    ram_lesen_d     = ~SchreibeDaten;
                    ram_schreiben_d = SchreibeDaten;
                    ram_adresse_d   = DatenAdresse;
                    ram_daten_d     = SchreibeDaten ? DatenRaus : ram_daten_q;
                    start_s         = 1'b1;
                    zustand_d       = ZUGRIFF;
                end else begin
                    zustand_d = FREI;
                end
            end
            ZUGRIFF: begin
                if (fertig_s || abgelaufen_s) begin
                    ram_lesen_d     = 1'b0;
                    ram_schreiben_d = 1'b0;
                    fehler_d        = ~fertig_s;
                    zustand_d       = ABSCHLUSS;
                    case (eigner_q)
                        EIGNER_INSTR: begin
                            instruktion_d   = wert_s;
                            instr_geladen_d = 1'b1;
                        end
                        EIGNER_DATEN: begin
                            if (schreiben_q) begin
                                daten_gespeichert_d = 1'b1;
                            end else begin
                                daten_rein_d    = wert_s;
                                daten_geladen_d = 1'b1;
                            end
                        end
                        EIGNER_LADER: begin
                            lade_fertig_d = 1'b1;
                        end
                        default: begin
                            fehler_d = 1'b1;
                        end
                    endcase
                end else begin
                    laeuft_s = 1'b1;
                end
            end
            ABSCHLUSS: begin
                zustand_d = FREI;
            end
            default: begin
                ram_lesen_d     = 1'b0;
                ram_schreiben_d = 1'b0;
                zustand_d       = FREI;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zustand_q           <= FREI;
            letzter_q           <= EIGNER_DATEN;
            eigner_q            <= EIGNER_INSTR;
            schreiben_q         <= 1'b0;
            ram_lesen_q         <= 1'b0;
            ram_schreiben_q     <= 1'b0;
            ram_adresse_q       <= '0;
            ram_daten_q         <= '0;
            instruktion_q       <= '0;
            daten_rein_q        <= '0;
            lade_fertig_q       <= 1'b0;
            instr_geladen_q     <= 1'b0;
            daten_geladen_q     <= 1'b0;
            daten_gespeichert_q <= 1'b0;
            fehler_q            <= 1'b0;
        end else begin
            zustand_q           <= zustand_d;
            letzter_q           <= letzter_d;
            eigner_q            <= eigner_d;
            schreiben_q         <= schreiben_d;
            ram_lesen_q         <= ram_lesen_d;
            ram_schreiben_q     <= ram_schreiben_d;
            ram_adresse_q       <= ram_adresse_d;
            ram_daten_q         <= ram_daten_d;
            instruktion_q       <= instruktion_d;
            daten_rein_q        <= daten_rein_d;
            lade_fertig_q       <= lade_fertig_d;
            instr_geladen_q     <= instr_geladen_d;
            daten_geladen_q     <= daten_geladen_d;
            daten_gespeichert_q <= daten_gespeichert_d;
            fehler_q            <= fehler_d;
        end
    end

    assign LadeFertig         = lade_fertig_q;
    assign Instruktion        = instruktion_q;
    assign InstruktionGeladen = instr_geladen_q;
    assign DatenRein          = daten_rein_q;
    assign DatenGeladen       = daten_geladen_q;
    assign DatenGespeichert   = daten_gespeichert_q;
    assign RamLesenAn         = ram_lesen_q;
    assign RamSchreibenAn     = ram_schreiben_q;
    assign RamAdresse         = ram_adresse_q;
    assign RamDatenRein       = ram_daten_q;
    assign Fehler             = fehler_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: bench-side RAM, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_speicher_arbiter;
    import speicher_pkg::*;

    localparam int W  = 32;
    localparam int A  = 32;
    localparam int TO = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          LadeAn, LeseInstruktion, LeseDaten, SchreibeDaten;
    logic [A-1:0]  LadeAdresse, InstruktionAdresse, DatenAdresse;
    logic [W-1:0]  LadeDaten, DatenRaus;
    logic          LadeFertig, InstruktionGeladen, DatenGeladen, DatenGespeichert;
    logic [W-1:0]  Instruktion, DatenRein;
    logic          RamLesenAn, RamSchreibenAn, Fehler;
    logic [A-1:0]  RamAdresse;
    logic [W-1:0]  RamDatenRein, RamDatenRaus;
    logic          RamDatenBereit, RamDatenGeschrieben;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram_mem [16];
    int          ram_lat   = 1;
    bit          ram_stumm = 1'b0;
    int          addr_log[$];
    int          done_log[$];
    int          lade_pulse = 0;

    speicher_arbiter #(.WORDSIZE(W), .ADRESSBREITE(A), .TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset),
        .LadeAn(LadeAn), .LadeAdresse(LadeAdresse), .LadeDaten(LadeDaten), .LadeFertig(LadeFertig),
        .LeseInstruktion(LeseInstruktion), .InstruktionAdresse(InstruktionAdresse),
        .Instruktion(Instruktion), .InstruktionGeladen(InstruktionGeladen),
        .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten), .DatenAdresse(DatenAdresse),
        .DatenRaus(DatenRaus), .DatenRein(DatenRein), .DatenGeladen(DatenGeladen),
        .DatenGespeichert(DatenGespeichert),
        .RamLesenAn(RamLesenAn), .RamSchreibenAn(RamSchreibenAn), .RamAdresse(RamAdresse),
        .RamDatenRein(RamDatenRein), .RamDatenRaus(RamDatenRaus),
        .RamDatenBereit(RamDatenBereit), .RamDatenGeschrieben(RamDatenGeschrieben),
        .Fehler(Fehler)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // RAM: answers a strobe ram_lat negedges after it appears, one cycle wide.
    initial begin
        int warte = 0;
        bit erledigt = 1'b0;
        for (int i = 0; i < 16; i++) ram_mem[i] = 32'h0;
        RamDatenBereit = 1'b0;
        RamDatenGeschrieben = 1'b0;
        RamDatenRaus = 32'h0;
        forever begin
            @(negedge Clock);
            RamDatenBereit = 1'b0;
            RamDatenGeschrieben = 1'b0;
            if (RamLesenAn || RamSchreibenAn) begin
                if (!erledigt) begin
                    warte++;
                    if (!ram_stumm && warte >= ram_lat) begin
                        erledigt = 1'b1;
                        if (RamSchreibenAn) begin
                            ram_mem[RamAdresse[3:0]] = RamDatenRein;
                            RamDatenGeschrieben = 1'b1;
                        end else begin
                            RamDatenRaus = ram_mem[RamAdresse[3:0]];
                            RamDatenBereit = 1'b1;
                        end
                    end
                end
            end else begin
                warte = 0;
                erledigt = 1'b0;
            end
        end
    end

    // Reference model: one transaction at a time, compared every cycle.
    initial begin
        bit          busy = 1'b0, cool = 1'b0, ok, m_wr = 1'b0;
        int          waited = 0, idle = 5;
        eigner_t     m_own = EIGNER_INSTR, m_last = EIGNER_DATEN;
        logic [31:0] m_addr = 32'h0, m_data = 32'h0, wert;
        logic [31:0] e_instr = 32'h0, e_daten = 32'h0;
        bit          e_lf, e_ig, e_dg, e_ds, e_f, cur;
        logic [31:0] ref_mem [16];
        logic        s_rst, s_la, s_li, s_ld, s_sd, s_ber, s_ges;
        logic [31:0] s_la_a, s_la_d, s_li_a, s_d_a, s_d_d;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        forever begin
            @(posedge Clock);
            s_rst = Reset; s_la = LadeAn; s_li = LeseInstruktion; s_ld = LeseDaten; s_sd = SchreibeDaten;
            s_ber = RamDatenBereit; s_ges = RamDatenGeschrieben;
            s_la_a = LadeAdresse; s_la_d = LadeDaten; s_li_a = InstruktionAdresse;
            s_d_a = DatenAdresse; s_d_d = DatenRaus;
            #1;
            {e_lf, e_ig, e_dg, e_ds, e_f} = 5'b0;
            if (!s_rst) begin
                busy = 1'b0; cool = 1'b0; m_last = EIGNER_DATEN;
                e_instr = 32'h0; e_daten = 32'h0;
            end else if (busy) begin
                waited++;
                ok = m_wr ? s_ges : s_ber;
                if (ok || waited == TO) begin
                    wert = ok ? ref_mem[m_addr[3:0]] : 32'h0;
                    e_f = !ok;
                    if (m_wr && ok) ref_mem[m_addr[3:0]] = m_data;
                    if (m_own == EIGNER_INSTR) begin
                        e_ig = 1'b1; e_instr = wert;
                    end else if (m_own == EIGNER_DATEN) begin
                        if (m_wr) e_ds = 1'b1;
                        else begin e_dg = 1'b1; e_daten = wert; end
                    end else begin
                        e_lf = 1'b1;
                    end
                    busy = 1'b0; cool = 1'b1;
                end
            end else if (cool) begin
                cool = 1'b0;
            end else if (s_la) begin
                busy = 1'b1; waited = 0; m_own = EIGNER_LADER; m_wr = 1'b1; m_addr = s_la_a; m_data = s_la_d;
            end else if (s_li && (!(s_ld || s_sd) || m_last == EIGNER_DATEN)) begin
                busy = 1'b1; waited = 0; m_own = EIGNER_INSTR; m_wr = 1'b0; m_addr = s_li_a; m_last = EIGNER_INSTR;
            end else if (s_ld || s_sd) begin
                busy = 1'b1; waited = 0; m_own = EIGNER_DATEN; m_wr = s_sd; m_addr = s_d_a; m_data = s_d_d;
                m_last = EIGNER_DATEN;
            end
            chk("ram_read_strobe", {31'b0, RamLesenAn}, {31'b0, busy && !m_wr});
            chk("ram_write_strobe", {31'b0, RamSchreibenAn}, {31'b0, busy && m_wr});
            if (busy) chk("ram_addr", RamAdresse, m_addr);
            if (busy && m_wr) chk("ram_wdata", RamDatenRein, m_data);
            chk("done_pulses", {27'b0, LadeFertig, InstruktionGeladen, DatenGeladen, DatenGespeichert, Fehler},
                {27'b0, e_lf, e_ig, e_dg, e_ds, e_f});
            chk("instr_word", Instruktion, e_instr);
            chk("data_word", DatenRein, e_daten);
            cur = RamLesenAn | RamSchreibenAn;
            if (cur && idle == 0 && !busy) chk("strobe_unexpected", 32'd1, 32'd0);
            if (cur && idle > 0) begin
                chk("idle_gap", (idle >= 1) ? 32'd1 : 32'd0, 32'd1);
                addr_log.push_back(int'(RamAdresse));
            end
            idle = cur ? 0 : idle + 1;
            if (InstruktionGeladen) done_log.push_back(0);
            if (DatenGeladen || DatenGespeichert) done_log.push_back(1);
            if (LadeFertig) begin done_log.push_back(2); lade_pulse++; end
        end
    end

    task automatic warte_fertig(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (LadeFertig || InstruktionGeladen || DatenGeladen || DatenGespeichert) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_done", {31'b0, ok}, 32'd1);
    endtask

    task automatic warte_strobe(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (RamLesenAn || RamSchreibenAn) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_strobe", {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int n;
        bit ok;
        int exp_tab[4] = '{0, 1, 0, 1};
        Reset = 1'b1;
        {LadeAn, LeseInstruktion, LeseDaten, SchreibeDaten} = 4'b0;
        LadeAdresse = 32'h0; LadeDaten = 32'h0; InstruktionAdresse = 32'h0;
        DatenAdresse = 32'h0; DatenRaus = 32'h0;
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("reset_strobe", {30'b0, RamLesenAn, RamSchreibenAn}, 32'd0);
        chk("reset_instr", Instruktion, 32'h0);
        chk("reset_pulses", {30'b0, LadeFertig, Fehler}, 32'd0);
        Reset = 1'b1;

        // Program loader: two words.
        LadeAn = 1'b1; LadeAdresse = 32'd0; LadeDaten = 32'h80200001;
        warte_fertig(20);
        LadeAn = 1'b0;
        @(negedge Clock);
        LadeAn = 1'b1; LadeAdresse = 32'd1; LadeDaten = 32'hBFE00003;
        warte_fertig(20);
        LadeAn = 1'b0;
        @(negedge Clock);
        chk("load_pulses", lade_pulse, 32'd2);
        chk("load_word0", ram_mem[0], 32'h80200001);
        chk("load_word1", ram_mem[1], 32'hBFE00003);

        // Single fetch of word 0.
        LeseInstruktion = 1'b1; InstruktionAdresse = 32'd0;
        @(negedge Clock);
        chk("fetch_strobe", {31'b0, RamLesenAn}, 32'd1);
        chk("fetch_addr", RamAdresse, 32'd0);
        warte_fertig(20);
        LeseInstruktion = 1'b0;
        chk("fetch_word", Instruktion, 32'h80200001);
        chk("fetch_idle", {31'b0, RamLesenAn}, 32'd0);

        // Both CPU ports held from reset: round-robin starting with the fetch.
        @(negedge Clock);
        Reset = 1'b0;
        LeseInstruktion = 1'b1; InstruktionAdresse = 32'd0;
        LeseDaten = 1'b1; DatenAdresse = 32'd1;
        repeat (2) @(negedge Clock);
        addr_log.delete();
        done_log.delete();
        Reset = 1'b1;
        for (int k = 0; k < 4; k++) warte_fertig(20);
        LeseInstruktion = 1'b0; LeseDaten = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rr_grants", addr_log.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_addr_order", addr_log[k], exp_tab[k]);
            chk("rr_done_order", done_log[k], exp_tab[k]);
        end
        chk("rr_data_word", DatenRein, 32'hBFE00003);

        // Loader arrives during a data write; it waits, then beats the fetch.
        ram_lat = 3;
        SchreibeDaten = 1'b1; DatenAdresse = 32'd5; DatenRaus = 32'h12345678;
        warte_strobe(10);
        LadeAn = 1'b1; LadeAdresse = 32'd6; LadeDaten = 32'hCAFE0006;
        LeseInstruktion = 1'b1; InstruktionAdresse = 32'd1;
        warte_fertig(20);
        chk("mid_write_first", {31'b0, DatenGespeichert}, 32'd1);
        SchreibeDaten = 1'b0;
        warte_fertig(20);
        chk("mid_loader_second", {31'b0, LadeFertig}, 32'd1);
        LadeAn = 1'b0;
        warte_fertig(20);
        chk("mid_fetch_third", {31'b0, InstruktionGeladen}, 32'd1);
        chk("mid_fetch_word", Instruktion, 32'hBFE00003);
        LeseInstruktion = 1'b0;
        chk("mid_word5", ram_mem[5], 32'h12345678);
        chk("mid_word6", ram_mem[6], 32'hCAFE0006);
        ram_lat = 1;
        @(negedge Clock);

        // Silent RAM: timeout after 16 access cycles.
        ram_stumm = 1'b1;
        LeseDaten = 1'b1; DatenAdresse = 32'd3;
        warte_strobe(10);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            n++;
            if (DatenGeladen) begin ok = 1'b1; break; end
        end
        chk("timeout_seen", {31'b0, ok}, 32'd1);
        chk("timeout_cycles", n, 32'd16);
        chk("timeout_fehler", {31'b0, Fehler}, 32'd1);
        chk("timeout_data", DatenRein, 32'h0);
        LeseDaten = 1'b0; ram_stumm = 1'b0;
        repeat (2) @(negedge Clock);

        // Reset in the middle of an access, then a clean fetch.
        ram_lat = 10;
        LeseInstruktion = 1'b1; InstruktionAdresse = 32'd0;
        warte_strobe(10);
        @(posedge Clock);
        #3 Reset = 1'b0;
        #1;
        chk("async_strobe_drop", {31'b0, RamLesenAn}, 32'd0);
        chk("async_instr_clear", Instruktion, 32'h0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1; ram_lat = 1;
        warte_fertig(20);
        chk("after_reset_fetch", Instruktion, 32'h80200001);
        LeseInstruktion = 1'b0;
        repeat (3) @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
